// File: rtl/gray_step_monitor_if.sv
// Bus between the Gray counter (master) and the step monitor (slave).
// The monitor watches gray_in and reports conversion, step/error events and lock status.
interface gray_step_monitor_if #(
  parameter int N  = 8,
  parameter int CW = 8
);
  logic [N-1:0]  gray_in;
  logic [N-1:0]  bin_out;
  logic          step_pulse;
  logic          err_pulse;
  logic          wrap_pulse;
  logic          locked;
  logic [CW-1:0] err_count;

  modport master (
    output gray_in,
    input  bin_out, step_pulse, err_pulse, wrap_pulse, locked, err_count
  );

  modport slave (
    input  gray_in,
    output bin_out, step_pulse, err_pulse, wrap_pulse, locked, err_count
  );
endinterface

// File: rtl/gray_step_monitor.sv
// Checks that a Gray-code bus only ever advances by legal +1 steps; reports
// per-event pulses, a saturating error count and a lock status.
module gray_step_monitor #(
  parameter int N          = 8,
  parameter int LOCK_STEPS = 4,
  parameter int CW         = 8
) (
  input  logic               clk,
  input  logic               reset,
  gray_step_monitor_if.slave mon
);

  localparam int RW = $clog2(LOCK_STEPS + 1);
  localparam logic [RW-1:0] RUN_LOCK = RW'(LOCK_STEPS);

  typedef enum logic [1:0] {EMPTY, UNLOCKED, LOCKED} state_t;

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [N-1:0]  s_q, p_q, bin_q;
  logic          s_vld_q;
  state_t        state_q, state_d;
  logic [RW-1:0] run_q, run_d;
  logic          step_q, step_d, err_q, err_d, wrap_q, wrap_d, locked_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0] bin_s, bin_p, diff;
  logic         changed, one_bit, good;

  // Stage-1 compare between the newest sample and the reference sample
  assign bin_s   = gray2bin(s_q);
  assign bin_p   = gray2bin(p_q);
  assign diff    = s_q ^ p_q;
  assign changed = |diff;
  assign one_bit = changed && ((diff & (diff - N'(1))) == '0);
  assign good    = one_bit && (bin_s == bin_p + N'(1));

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    step_d  = 1'b0;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      // p_q only holds a real sample once s_q has been loaded once
      EMPTY: if (s_vld_q) state_d = UNLOCKED;
      UNLOCKED, LOCKED: begin
        if (changed && good) begin
          step_d = 1'b1;
          wrap_d = &bin_p;
          if (state_q == UNLOCKED) begin
            if (run_q + RW'(1) >= RUN_LOCK) begin
              run_d   = RUN_LOCK;
              state_d = LOCKED;
            end else begin
              run_d = run_q + RW'(1);
            end
          end
        end else if (changed) begin
          err_d   = 1'b1;
          run_d   = '0;
          state_d = UNLOCKED;
          cnt_d   = sat_inc(cnt_q);
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '0;
      p_q      <= '0;
      s_vld_q  <= 1'b0;
      bin_q    <= '0;
      state_q  <= EMPTY;
      run_q    <= '0;
      step_q   <= 1'b0;
      err_q    <= 1'b0;
      wrap_q   <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s_q      <= mon.gray_in;
      p_q      <= s_q;
      s_vld_q  <= 1'b1;
      bin_q    <= bin_s;
      state_q  <= state_d;
      run_q    <= run_d;
      step_q   <= step_d;
      err_q    <= err_d;
      wrap_q   <= wrap_d;
      locked_q <= (state_d == LOCKED);
      cnt_q    <= cnt_d;
    end
  end

  assign mon.bin_out    = bin_q;
  assign mon.step_pulse = step_q;
  assign mon.err_pulse  = err_q;
  assign mon.wrap_pulse = wrap_q;
  assign mon.locked     = locked_q;
  assign mon.err_count  = cnt_q;

endmodule
